// File: rtl/memory_stage_lsu.sv
// memory_stage_lsu: load/store memory stage with sub-word lanes, request/grant
// handshake, misalignment and bus-timeout detection, and a registered writeback.
module memory_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [XLEN-1:0]   pc_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [XLEN-1:0]   wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_pc,
    output logic              exc_misaligned,
    output logic              exc_bus
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, sdata_q, sdata_d, pc_q, pc_d;
    logic [2:0]      f3_q, f3_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, exc_mis_q, exc_mis_d, exc_bus_q, exc_bus_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;

    logic [1:0]      in_sz, sz;
    logic            in_mem, in_ill, in_mis, req, load_done, timeout;
    logic [XLEN-1:0] lane, load_val, wdata;
    logic [BW-1:0]   be_base;

    assign in_sz  = funct3[1:0];
    assign in_mem = mem_read | mem_write;
    // 110 is LWU: only a legal load, and only on a 64-bit datapath
    assign in_ill = (XLEN == 32 && in_sz == 2'd3) || funct3 == 3'b111 ||
                    (funct3 == 3'b110 && (mem_write || XLEN == 32));
    assign in_mis = in_sz == 2'd1 ? alu_result[0] :
                    in_sz == 2'd2 ? |alu_result[1:0] :
                    in_sz == 2'd3 ? |alu_result[2:0] : 1'b0;

    assign sz       = f3_q[1:0];
    assign lane     = mem_rdata >> {addr_q[OW-1:0], 3'b000};
    assign load_val = sz == 2'd0 ? (f3_q[2] ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]))) :
                      sz == 2'd1 ? (f3_q[2] ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]))) :
                      sz == 2'd2 ? (f3_q[2] ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]))) : lane;
    assign be_base  = sz == 2'd0 ? BW'(1) : sz == 2'd1 ? BW'(3) : sz == 2'd2 ? BW'(15) : {BW{1'b1}};
    assign wdata    = sz == 2'd0 ? {BW{sdata_q[7:0]}} :
                      sz == 2'd1 ? {BW/2{sdata_q[15:0]}} :
                      sz == 2'd2 ? {XLEN/32{sdata_q[31:0]}} : sdata_q;

    assign req       = state_q == REQ;
    assign load_done = !st_q && mem_rvalid && ((req && mem_gnt) || state_q == WAIT);
    assign timeout   = TIMEOUT > 0 && state_q == WAIT && cnt_q == CW'(TIMEOUT - 1);

    assign stall     = state_q != IDLE;
    assign mem_req   = req;
    assign mem_we    = req & st_q;
    assign mem_addr  = req ? {addr_q[XLEN-1:OW], OW'(0)} : '0;
    assign mem_be    = req ? be_base << addr_q[OW-1:0] : '0;
    assign mem_wdata = req & st_q ? wdata : '0;

    assign wb_valid       = wb_valid_q;
    assign wb_we          = wb_we_q;
    assign wb_data        = wb_data_q;
    assign wb_rd          = wb_rd_q;
    assign wb_pc          = wb_pc_q;
    assign exc_misaligned = exc_mis_q;
    assign exc_bus        = exc_bus_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        st_d       = st_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_data_d  = '0;
        exc_mis_d  = 1'b0;
        exc_bus_d  = 1'b0;
        if (state_q == IDLE && in_valid) begin
            if (!in_mem) begin
                wb_valid_d = 1'b1;
                wb_we_d    = 1'b1;
                wb_data_d  = alu_result;
            end else begin
                addr_d     = alu_result;
                sdata_d    = store_data;
                f3_d       = funct3;
                rd_d       = rd_in;
                pc_d       = pc_in;
                st_d       = mem_write;
                wb_valid_d = in_ill | in_mis;
                exc_bus_d  = in_ill;
                exc_mis_d  = !in_ill & in_mis;
                state_d    = (in_ill | in_mis) ? IDLE : REQ;
            end
        end else if (load_done) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = |rd_q;
            wb_data_d  = load_val;
        end else if (req && mem_gnt) begin
            state_d    = st_q ? IDLE : WAIT;
            wb_valid_d = st_q;
            cnt_d      = '0;
        end else if (timeout) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            exc_bus_d  = 1'b1;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        wb_rd_d = !wb_valid_d ? '0 : state_q == IDLE ? rd_in : rd_q;
        wb_pc_d = !wb_valid_d ? '0 : state_q == IDLE ? pc_in : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            sdata_q    <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            st_q       <= 1'b0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_pc_q    <= '0;
            exc_mis_q  <= 1'b0;
            exc_bus_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_pc_q    <= wb_pc_d;
            exc_mis_q  <= exc_mis_d;
            exc_bus_q  <= exc_bus_d;
        end
    end
endmodule

// File: tb/tb_memory_stage_lsu.sv
// tb_memory_stage_lsu: randomized and directed checks of memory_stage_lsu
// against a byte-level reference model of loads, stores and handshakes.
module tb_memory_stage_lsu;
    localparam int XLEN    = 32;
    localparam int RD_W    = 5;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] alu_result = '0, store_data = '0, pc_in = '0, mem_rdata = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd_in = '0;
    logic        stall, mem_req, mem_we, wb_valid, wb_we, exc_misaligned, exc_bus;
    logic [31:0] mem_addr, mem_wdata, wb_data, wb_pc;
    logic [3:0]  mem_be;
    logic [4:0]  wb_rd;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        done, we, mis, bus, stall_wb, unstable, mwe;
        logic [31:0] data, pc, mpc, addr, wdata;
        logic [4:0]  rd;
        logic [3:0]  be;
        int          req, stall;
    } obs_t;

    memory_stage_lsu #(.XLEN(XLEN), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .rd_in(rd_in), .pc_in(pc_in), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_pc(wb_pc), .exc_misaligned(exc_misaligned), .exc_bus(exc_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pure byte arithmetic on the access width
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_illegal(input logic [2:0] f3);
        return f3[1:0] == 2'd3 || f3 == 3'b110;
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << nbytes(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nbytes(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
        longint unsigned r, mask, v;
        int n;
        n    = nbytes(f3);
        r    = rdat;
        mask = (64'd1 << (8 * n)) - 1;
        v    = (r >> (8 * (a % 4))) & mask;
        if (!f3[2] && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic do_alu(input logic [31:0] a, input logic [4:0] rd, output obs_t o);
        o = '{default: '0};
        o.mpc = $urandom;
        alu_result = a; rd_in = rd; pc_in = o.mpc; mem_read = 1'b0; mem_write = 1'b0; in_valid = 1'b1;
        o.stall = int'(stall);
        tick();
        in_valid = 1'b0;
        o.done = wb_valid; o.we = wb_we; o.data = wb_data; o.rd = wb_rd; o.pc = wb_pc;
        o.mis = exc_misaligned; o.bus = exc_bus; o.stall_wb = stall;
    endtask

    // gd: REQ cycles before grant; rvd: cycles after grant to rvalid (0 = same cycle, <0 = never)
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rdat, input logic [4:0] rd, input int gd, input int rvd,
                             input logic noise, output obs_t o);
        int gcyc;
        o = '{default: '0};
        gcyc = -1;
        o.mpc = $urandom;
        alu_result = a; store_data = sd; mem_read = !st; mem_write = st; funct3 = f3; rd_in = rd;
        pc_in = o.mpc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; alu_result = $urandom; store_data = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
        mem_read = 1'b0; mem_write = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (wb_valid) break;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (noise) begin
                in_valid = 1'b1; alu_result = $urandom; pc_in = $urandom;
            end
            if (stall) o.stall++;
            if (mem_req) begin
                if (o.req == 0) begin
                    o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.mwe = mem_we;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o.addr, o.be, o.wdata, o.mwe}) begin
                    o.unstable = 1'b1;
                end
                if (o.req == gd) begin
                    mem_gnt = 1'b1;
                    gcyc = c;
                end
                o.req++;
            end
            if (!st && gcyc >= 0 && c - gcyc == rvd) begin
                mem_rvalid = 1'b1;
                mem_rdata = rdat;
            end
            tick();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; in_valid = 1'b0;
        o.done = wb_valid; o.we = wb_we; o.data = wb_data; o.rd = wb_rd; o.pc = wb_pc;
        o.mis = exc_misaligned; o.bus = exc_bus; o.stall_wb = stall;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; mem_read = 1'b1; alu_result = 32'h104;
        tick();
        tick();
        vectors++;
        if ({stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_we, wb_data, wb_rd, wb_pc,
             exc_misaligned, exc_bus} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got stall=%b req=%b wbv=%b addr=%h wb_data=%h expected all zero",
                     stall, mem_req, wb_valid, mem_addr, wb_data);
        end
        in_valid = 1'b0; mem_read = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        obs_t o;
        do_alu(32'h1234, 5'd5, o);
        vectors++;
        if ({o.done, o.we, o.rd, o.pc, o.mis, o.bus, o.stall_wb, o.stall != 0} !== {1'b1, 1'b1, 5'd5, o.mpc, 4'b0000}) begin
            miscompares++;
            $display("FAIL alu_status: got v=%b we=%b rd=%0d pc=%h exc=%b%b stall=%b/%0d expected 1 1 5 %h 00 0/0",
                     o.done, o.we, o.rd, o.pc, o.mis, o.bus, o.stall_wb, o.stall, o.mpc);
        end
        vectors++;
        if (o.data !== 32'h1234) begin
            miscompares++;
            $display("FAIL alu_data: got %h expected 00001234", o.data);
        end
        tick();
        vectors++;
        if (wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_pulse: got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            do_alu(v, 5'(i + 1), o);
            vectors++;
            if ({o.done, o.we, o.data, o.rd, o.stall_wb} !== {1'b1, 1'b1, v, 5'(i + 1), 1'b0}) begin
                miscompares++;
                $display("FAIL b2b_alu%0d: got v=%b we=%b data=%h rd=%0d expected 1 1 %h %0d", i, o.done, o.we, o.data, o.rd, v, i + 1);
            end
        end
    endtask

    task automatic test_store();
        obs_t o;
        do_access(1'b1, 3'b000, 32'h103, 32'hAB, 32'h0, 5'd9, 2, 0, 1'b1, o);
        vectors++;
        if ({o.addr, o.be, o.wdata, o.mwe, o.unstable} !== {32'h100, 4'h8, 32'hABABABAB, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sb_bus: got addr=%h be=%h wdata=%h we=%b unstable=%b expected 100 8 abababab 1 0",
                     o.addr, o.be, o.wdata, o.mwe, o.unstable);
        end
        vectors++;
        if ({o.done, o.we, o.mis, o.bus, o.stall_wb} !== 5'b10000 || o.req != 3 || o.stall != 3) begin
            miscompares++;
            $display("FAIL sb_complete: got v=%b we=%b req=%0d stall=%0d expected 1 0 3 3", o.done, o.we, o.req, o.stall);
        end
    endtask

    task automatic test_load_ext();
        obs_t o;
        do_access(1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000, 5'd3, 0, 3, 1'b0, o);
        vectors++;
        if ({o.done, o.we, o.data, o.be, o.addr} !== {1'b1, 1'b1, 32'hFFFFFF80, 4'h4, 32'h100} || o.stall != 4) begin
            miscompares++;
            $display("FAIL lb_sext: got v=%b we=%b data=%h be=%h stall=%0d expected 1 1 ffffff80 4 4", o.done, o.we, o.data, o.be, o.stall);
        end
        do_access(1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000, 5'd3, 0, 3, 1'b0, o);
        vectors++;
        if ({o.done, o.we, o.data} !== {1'b1, 1'b1, 32'h00000080}) begin
            miscompares++;
            $display("FAIL lbu_zext: got v=%b we=%b data=%h expected 1 1 00000080", o.done, o.we, o.data);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_access(1'b0, 3'b010, 32'h202, 32'h0, 32'h0, 5'd4, 0, 0, 1'b0, o);
        vectors++;
        if ({o.done, o.we, o.mis, o.bus, o.stall_wb, o.rd} !== {5'b10100, 5'd4} || o.req != 0 || o.stall != 0) begin
            miscompares++;
            $display("FAIL lw_misaligned: got v=%b we=%b mis=%b bus=%b req=%0d stall=%0d expected 1 0 1 0 0 0",
                     o.done, o.we, o.mis, o.bus, o.req, o.stall);
        end
        do_access(1'b1, 3'b001, 32'h201, 32'h5555, 32'h0, 5'd0, 0, 0, 1'b0, o);
        vectors++;
        if ({o.done, o.we, o.mis, o.bus, o.stall_wb} !== 5'b10100 || o.req != 0 || o.stall != 0) begin
            miscompares++;
            $display("FAIL sh_misaligned: got v=%b we=%b mis=%b bus=%b req=%0d stall=%0d expected 1 0 1 0 0 0",
                     o.done, o.we, o.mis, o.bus, o.req, o.stall);
        end
        do_access(1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 5'd4, 0, 0, 1'b0, o);
        vectors++;
        if ({o.done, o.we, o.mis, o.bus} !== 4'b1001 || o.req != 0) begin
            miscompares++;
            $display("FAIL ld_illegal: got v=%b we=%b mis=%b bus=%b req=%0d expected 1 0 0 1 0", o.done, o.we, o.mis, o.bus, o.req);
        end
    endtask

    task automatic test_same_cycle();
        obs_t o;
        do_access(1'b0, 3'b010, 32'h400, 32'h0, 32'hDEADBEEF, 5'd8, 0, 0, 1'b0, o);
        vectors++;
        if ({o.done, o.we, o.data, o.be} !== {1'b1, 1'b1, 32'hDEADBEEF, 4'hF} || o.stall != 1) begin
            miscompares++;
            $display("FAIL lw_gnt_rvalid: got v=%b data=%h be=%h stall=%0d expected 1 deadbeef f 1", o.done, o.data, o.be, o.stall);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_access(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 5'd8, 0, -1, 1'b0, o);
        vectors++;
        if ({o.done, o.we, o.mis, o.bus, o.stall_wb} !== 5'b10010 || o.stall != 1 + TIMEOUT) begin
            miscompares++;
            $display("FAIL lw_timeout: got v=%b we=%b bus=%b stall=%0d expected 1 0 1 %0d", o.done, o.we, o.bus, o.stall, 1 + TIMEOUT);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        alu_result = 32'h300; mem_read = 1'b1; funct3 = 3'b010; rd_in = 5'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; mem_read = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        tick();
        vectors++;
        if ({stall, mem_req, wb_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL mid_wait: got stall=%b req=%b wbv=%b expected 1 0 0", stall, mem_req, wb_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({stall, mem_req, wb_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset: got stall=%b req=%b wbv=%b expected 0 0 0", stall, mem_req, wb_valid);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen |= wb_valid;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_rvalid: got wb_valid seen=%b expected 0", seen);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic st, ill, mis, tout, exp_we;
        logic [2:0] f3;
        logic [31:0] a, sd, rdat;
        logic [4:0] rd;
        int gd, rvd, exp_req, exp_stall;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom; rd = 5'($urandom);
                do_alu(a, rd, o);
                vectors++;
                if ({o.done, o.we, o.data, o.rd, o.pc, o.mis, o.bus} !== {2'b11, a, rd, o.mpc, 2'b00}) begin
                    miscompares++;
                    $display("FAIL rnd_alu%0d: got v=%b we=%b data=%h rd=%0d expected 1 1 %h %0d", k, o.done, o.we, o.data, o.rd, a, rd);
                end
                continue;
            end
            st = 1'($urandom); f3 = 3'($urandom); a = $urandom; sd = $urandom; rdat = $urandom; rd = 5'($urandom);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            gd = $urandom_range(0, 3);
            rvd = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
            do_access(st, f3, a, sd, rdat, rd, gd, rvd, 1'($urandom), o);
            ill = ref_illegal(f3);
            mis = !ill && ref_misaligned(f3, a);
            tout = !st && !ill && !mis && rvd < 0;
            exp_we = !(ill || mis || st || tout) && rd != 0;
            exp_req = (ill || mis) ? 0 : gd + 1;
            exp_stall = (ill || mis) ? 0 : gd + 1 + (st ? 0 : (rvd < 0 ? TIMEOUT : rvd));
            vectors++;
            if ({o.done, o.we, o.mis, o.bus, o.rd, o.pc, o.stall_wb} !== {1'b1, exp_we, mis, ill || tout, rd, o.mpc, 1'b0}) begin
                miscompares++;
                $display("FAIL rnd_status%0d: f3=%b st=%b a=%h got v=%b we=%b mis=%b bus=%b rd=%0d expected 1 %b %b %b %0d",
                         k, f3, st, a, o.done, o.we, o.mis, o.bus, o.rd, exp_we, mis, ill || tout, rd);
            end
            vectors++;
            if (o.req != exp_req || o.stall != exp_stall) begin
                miscompares++;
                $display("FAIL rnd_timing%0d: got req=%0d stall=%0d expected %0d %0d", k, o.req, o.stall, exp_req, exp_stall);
            end
            if (exp_we) begin
                vectors++;
                if (o.data !== ref_load(f3, a, rdat)) begin
                    miscompares++;
                    $display("FAIL rnd_load%0d: f3=%b a=%h rdata=%h got %h expected %h", k, f3, a, rdat, o.data, ref_load(f3, a, rdat));
                end
            end
            if (!ill && !mis) begin
                vectors++;
                if ({o.addr, o.be, o.mwe, o.unstable, st ? o.wdata : 32'h0} !==
                    {a & ~32'h3, ref_be(f3, a), st, 1'b0, st ? ref_wdata(f3, sd) : 32'h0}) begin
                    miscompares++;
                    $display("FAIL rnd_bus%0d: f3=%b st=%b got addr=%h be=%h we=%b wdata=%h unstable=%b expected %h %h %b %h 0",
                             k, f3, st, o.addr, o.be, o.mwe, o.wdata, o.unstable, a & ~32'h3, ref_be(f3, a), st, ref_wdata(f3, sd));
                end
            end
            tick();
            vectors++;
            if (wb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_pulse%0d: got wb_valid=%b expected 0", k, wb_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_store();
        test_load_ext();
        test_misaligned();
        test_same_cycle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
